// File: rtl/memarb_pkg.sv
// Shared types and derived constants for the N-channel memory port arbiter.
package memarb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WBEATS,
    WACK,
    RBEATS,
    DONE
  } state_t;

  localparam int unsigned DEF_BLOCK_W   = 512;
  localparam int unsigned DEF_SUBBLOCKS = 4;

  function automatic int unsigned calc_bw(input int unsigned block_w, input int unsigned subblocks);
    return block_w / subblocks;
  endfunction

  function automatic int unsigned calc_sb_log2(input int unsigned subblocks);
    return $clog2(subblocks);
  endfunction

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned BW      = calc_bw(DEF_BLOCK_W, DEF_SUBBLOCKS);
  localparam int unsigned SB_LOG2 = calc_sb_log2(DEF_SUBBLOCKS);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NCH = 2,
  parameter int unsigned IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  output logic [NCH-1:0] grant,
  output logic [IW-1:0]  idx,
  output logic           any
);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned off = 1; off <= NCH; off++) begin
      cand = IW'((32'(ptr) + off) % NCH);
      if (!found && req[cand]) begin
        found       = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/mem_port_arbiter.sv
// N-channel block arbiter onto a subblock-strobed external memory port.
// Optional counters stat_grants/stat_wait are built when MEMARB_STATS_EN is defined.
module mem_port_arbiter
  import memarb_pkg::*;
#(
  parameter  int unsigned NCH       = 2,
  parameter  int unsigned ADDR_W    = 32,
  parameter  int unsigned BLOCK_W   = DEF_BLOCK_W,
  parameter  int unsigned SUBBLOCKS = DEF_SUBBLOCKS,
  localparam int unsigned BEAT_W    = calc_bw(BLOCK_W, SUBBLOCKS),
  localparam int unsigned STRB_W    = calc_sb_log2(SUBBLOCKS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH-1:0]         req_en,
  input  logic [NCH-1:0]         req_we,
  input  logic [NCH*ADDR_W-1:0]  req_addr,
  input  logic [NCH*BLOCK_W-1:0] req_wdata,
  output logic [NCH-1:0]         req_ready,
  output logic [BLOCK_W-1:0]     req_rdata,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_en,
  output logic                   mem_we,
  input  logic                   mem_accR,
  input  logic                   mem_accW,
  output logic [STRB_W-1:0]      mem_dout_strobe,
  output logic [BEAT_W-1:0]      mem_dout,
  input  logic [STRB_W-1:0]      mem_din_strobe,
  input  logic [BEAT_W-1:0]      mem_din,
  input  logic                   mem_ready
`ifdef MEMARB_STATS_EN
  ,
  output logic [NCH*32-1:0]      stat_grants,
  output logic [31:0]            stat_wait
`endif
);

  localparam int unsigned IW = idx_w(NCH);

  state_t state_q, state_d;

  logic [IW-1:0]                      ptr_q, gnt_q;
  logic                               we_q;
  logic [ADDR_W-1:0]                  addr_q;
  logic [SUBBLOCKS-1:0][BEAT_W-1:0]   wdata_q, rdata_q;
  logic [SUBBLOCKS-1:0]               mask_q, mask_d, mask_hit;
  logic [STRB_W-1:0]                  beat_q;

  logic [NCH-1:0]     req_vec, arb_grant, gnt_oh;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;
  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [BLOCK_W-1:0] sel_wdata;
  logic               accepted;

  assign req_vec = req_en | req_we;

  rr_arbiter #(
    .NCH (NCH),
    .IW  (IW)
  ) u_rr_arbiter (
    .req   (req_vec),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // A channel asserting both en and we is latched as a write.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (arb_grant[i]) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*BLOCK_W +: BLOCK_W];
      end
    end
  end

  always_comb begin
    gnt_oh        = '0;
    gnt_oh[gnt_q] = 1'b1;
  end

  assign accepted = we_q ? mem_accW : mem_accR;
  assign mask_hit = mem_ready ? (SUBBLOCKS'(1) << mem_din_strobe) : '0;
  assign mask_d   = mask_q | mask_hit;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (arb_any) state_d = ISSUE;
      ISSUE:   if (accepted) state_d = we_q ? WBEATS : RBEATS;
      WBEATS:  if (beat_q == STRB_W'(SUBBLOCKS - 1)) state_d = WACK;
      WACK:    if (mem_ready) state_d = DONE;
      RBEATS:  if (&mask_d) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NCH - 1);
      gnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mask_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (arb_any) begin
            ptr_q   <= arb_idx;
            gnt_q   <= arb_idx;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            mask_q  <= '0;
            beat_q  <= '0;
          end
        end
        WBEATS: beat_q <= beat_q + STRB_W'(1);
        RBEATS: begin
          // Duplicate strobes overwrite the beat; the mask keeps completion exact.
          if (mem_ready) begin
            rdata_q[mem_din_strobe] <= mem_din;
            mask_q                  <= mask_d;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_addr        = addr_q;
    mem_en          = (state_q == ISSUE) && !we_q;
    mem_we          = (state_q == ISSUE) && we_q;
    mem_dout_strobe = '0;
    mem_dout        = '0;
    if (state_q == WBEATS) begin
      mem_dout_strobe = beat_q;
      mem_dout        = wdata_q[beat_q];
    end
    req_ready = (state_q == DONE) ? gnt_oh : '0;
    req_rdata = rdata_q;
  end

`ifdef MEMARB_STATS_EN
  logic [NCH-1:0][31:0] grants_q;
  logic [31:0]          wait_q;
  logic                 others_waiting;

  assign others_waiting = (state_q != IDLE) && (|(req_vec & ~gnt_oh));

  always_ff @(posedge clk) begin
    if (reset) begin
      grants_q <= '0;
      wait_q   <= '0;
    end else begin
      if ((state_q == DONE) && (grants_q[gnt_q] != '1))
        grants_q[gnt_q] <= grants_q[gnt_q] + 32'd1;
      if (others_waiting && (wait_q != '1))
        wait_q <= wait_q + 32'd1;
    end
  end

  assign stat_grants = grants_q;
  assign stat_wait   = wait_q;
`endif

endmodule
